// File: rtl/intrapred_sequencer.sv
// intrapred_sequencer: frame-level controller for the intra-prediction datapath.
// Runs one 16x16 and sixteen 4x4 passes per macroblock and picks the cheaper partition.
module intrapred_sequencer #(
    parameter int BIAS    = 24,
    parameter int SAD4_W  = 12,
    parameter int SAD16_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [12:0]        frame_mbs,
    output logic               enable,
    output logic               mode16,
    output logic [12:0]        mbnumber,
    output logic [3:0]         blkidx,
    input  logic               sad16_valid,
    input  logic [SAD16_W-1:0] sad16,
    input  logic               sad4_valid,
    input  logic [SAD4_W-1:0]  sad4,
    output logic               mb_valid,
    input  logic               mb_ready,
    output logic               mb_use4x4,
    output logic [SAD16_W-1:0] mb_cost,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE16,
        WAIT16,
        ISSUE4,
        WAIT4,
        DECIDE,
        OUTPUT
    } state_t;

    localparam logic [SAD16_W:0] BIAS_EXT = (SAD16_W+1)'(BIAS);

    state_t             state_q, state_d;
    logic [12:0]        mbs_q, mbs_d;
    logic [12:0]        mbn_q, mbn_d;
    logic [3:0]         blk_q, blk_d;
    logic [SAD16_W-1:0] acc_q, acc_d;
    logic [SAD16_W-1:0] s16_q, s16_d;
    logic [SAD16_W-1:0] cost_q, cost_d;
    logic               use4_q, use4_d;
    logic               done_q, done_d;

    logic [SAD16_W:0]   t_raw;
    logic [SAD16_W-1:0] t_sat;
    logic               t_less;
    logic               last_mb;

    // Biased 4x4 cost, one bit wider so the bias can never wrap around.
    assign t_raw   = {1'b0, acc_q} + BIAS_EXT;
    assign t_sat   = t_raw[SAD16_W] ? '1 : t_raw[SAD16_W-1:0];
    assign t_less  = (t_sat < s16_q);
    assign last_mb = (mbn_q == (mbs_q - 13'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mbs_q   <= '0;
            mbn_q   <= '0;
            blk_q   <= '0;
            acc_q   <= '0;
            s16_q   <= '0;
            cost_q  <= '0;
            use4_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mbs_q   <= mbs_d;
            mbn_q   <= mbn_d;
            blk_q   <= blk_d;
            acc_q   <= acc_d;
            s16_q   <= s16_d;
            cost_q  <= cost_d;
            use4_q  <= use4_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mbs_d    = mbs_q;
        mbn_d    = mbn_q;
        blk_d    = blk_q;
        acc_d    = acc_q;
        s16_d    = s16_q;
        cost_d   = cost_q;
        use4_d   = use4_q;
        done_d   = 1'b0;
        enable   = 1'b0;
        mode16   = 1'b0;
        mb_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_mbs == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mbs_d   = frame_mbs;
                        mbn_d   = '0;
                        state_d = ISSUE16;
                    end
                end
            end
            ISSUE16: begin
                enable  = 1'b1;
                mode16  = 1'b1;
                acc_d   = '0;
                state_d = WAIT16;
            end
            WAIT16: begin
                mode16 = 1'b1;
                if (sad16_valid) begin
                    s16_d   = sad16;
                    blk_d   = '0;
                    state_d = ISSUE4;
                end
            end
            ISSUE4: begin
                enable  = 1'b1;
                state_d = WAIT4;
            end
            WAIT4: begin
                if (sad4_valid) begin
                    acc_d = acc_q + SAD16_W'(sad4);
                    if (blk_q == 4'd15) begin
                        state_d = DECIDE;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = ISSUE4;
                    end
                end
            end
            DECIDE: begin
                // A tie keeps the 16x16 partition.
                use4_d  = t_less;
                cost_d  = t_less ? acc_q : s16_q;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                mb_valid = 1'b1;
                if (mb_ready) begin
                    if (last_mb) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mbn_d   = mbn_q + 13'd1;
                        state_d = ISSUE16;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign mbnumber   = mbn_q;
    assign blkidx     = blk_q;
    assign mb_use4x4  = use4_q;
    assign mb_cost    = cost_q;
    assign frame_done = done_q;

endmodule

// File: doc/intrapred_sequencer.md
# intrapred_sequencer

Frame-level controller for the intra-prediction datapath. It steps `mbnumber` through every macroblock of a frame and runs one Luma 16x16 pass and sixteen Luma 4x4 passes per macroblock, launching each pass with a one-cycle `enable`. It accumulates the best-mode SAD returned by each pass and chooses the 4x4 or 16x16 luma partition. The decision is handed downstream through a valid/ready handshake.

## Interface
- `BIAS`, default 24: cost penalty added to the 4x4 SAD sum before it is compared with the 16x16 SAD.
- `SAD4_W`, default 12: width of the SAD returned by a 4x4 pass.
- `SAD16_W`, default 16: width of the 16x16 SAD and of the accumulated cost.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  frame start pulse; sampled only in IDLE.
- `frame_mbs`  in  13  macroblock count of the frame; sampled when `start` is accepted.
- `enable`  out  1  one-cycle launch pulse to the datapath.
- `mode16`  out  1  1 = current pass is 16x16; 0 = current pass is 4x4.
- `mbnumber`  out  13  current macroblock index.
- `blkidx`  out  4  current 4x4 sub-block index, 0..15.
- `sad16_valid`  in  1  16x16 pass result strobe.
- `sad16`  in  SAD16_W  best-mode SAD of the 16x16 pass.
- `sad4_valid`  in  1  4x4 pass result strobe.
- `sad4`  in  SAD4_W  best-mode SAD of the current 4x4 sub-block.
- `mb_valid`  out  1  decision available; held until accepted.
- `mb_ready`  in  1  downstream accepts the decision.
- `mb_use4x4`  out  1  1 = 4x4 partition chosen.
- `mb_cost`  out  SAD16_W  SAD of the chosen partition.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last macroblock is accepted.

## Operation
- FSM states: IDLE, ISSUE16, WAIT16, ISSUE4, WAIT4, DECIDE, OUTPUT.
- IDLE + `start`:
  - `frame_mbs`=0: pulse `frame_done` next cycle and stay in IDLE.
  - otherwise: latch `frame_mbs`, set `mbnumber`=0, go to ISSUE16.
- ISSUE16: `enable`=1, `mode16`=1, clear the 4x4 accumulator, go to WAIT16.
- WAIT16: hold until `sad16_valid`, capture `sad16`, set `blkidx`=0, go to ISSUE4.
- ISSUE4: `enable`=1, `mode16`=0, go to WAIT4.
- WAIT4: on `sad4_valid`, add zero-extended `sad4` to the accumulator.
  - `blkidx`=15: go to DECIDE.
  - otherwise: increment `blkidx`, go to ISSUE4.
- DECIDE:
  - t = accumulator + BIAS, computed at SAD16_W+1 bits and saturated to 2^SAD16_W-1.
  - `mb_use4x4` = (t < sad16), strict; a tie selects 16x16.
  - `mb_cost` = `mb_use4x4` ? accumulator : sad16.
  - Register both and go to OUTPUT.
- OUTPUT: `mb_valid`=1; `mb_use4x4` and `mb_cost` stay stable until `mb_ready`. On `mb_valid`&&`mb_ready`:
  - `mbnumber` = latched count − 1: pulse `frame_done`, go to IDLE.
  - otherwise: increment `mbnumber`, go to ISSUE16.
- Accumulator width is SAD16_W. 16 × (2^SAD4_W − 1) must fit in it; with the defaults the maximum is 65520.
- `sad16_valid` and `sad4_valid` are honoured only in their own WAIT state. In every other state they are ignored, with no capture and no accumulation.
- `start` while `busy` is ignored; `frame_mbs` changes mid-frame have no effect.
- `mbnumber` and `blkidx` stay stable from ISSUE through the end of the matching WAIT.

## Timing
- Reset values:
  - `enable`, `mode16`, `mb_valid`, `mb_use4x4`, `busy`, `frame_done` = 0.
  - `mbnumber`, `blkidx`, `mb_cost` = 0.
  - State = IDLE.
- `start` accepted in cycle 0: `busy`=1 and ISSUE16 in cycle 1.
- Results may return one cycle after `enable` at the earliest; any longer latency is waited out indefinitely.
- With 1-cycle result latency and `mb_ready` tied high, a macroblock takes 36 cycles:
  - 2 cycles for the 16x16 pass;
  - 32 cycles for the 4x4 passes;
  - 1 cycle in DECIDE;
  - 1 cycle in OUTPUT.
- `frame_done` is asserted the cycle after the final handshake, coincident with the return to IDLE and `busy`=0.
- Reset asserted mid-frame: outputs clear immediately (asynchronous), and the frame is abandoned with no `frame_done`.

## Test plan
- `frame_mbs`=1, 1-cycle responder, `sad4`=10 ×16, `sad16`=200 -> `mb_use4x4`=1, `mb_cost`=160, `frame_done` 36 cycles after `busy` rises.
- Tie: `sad4`=10 ×16, `sad16`=184 -> `mb_use4x4`=0, `mb_cost`=184.
- Saturation: `sad4`=4095 ×16, `sad16`=65535 -> t saturates to 65535, `mb_use4x4`=0, `mb_cost`=65535; `sad16`=65534 gives the same decision.
- `frame_mbs`=3, random result latency 1–5, `mb_ready` low for 4 cycles per macroblock:
  - `mbnumber` sequence is 0,1,2;
  - exactly 17 `enable` pulses per macroblock;
  - outputs stable while `mb_valid`=1 and `mb_ready`=0;
  - one `frame_done`.
- Spurious `sad4_valid` in WAIT16 and in OUTPUT, and `start` while busy -> no change to the accumulator, `blkidx` or `mbnumber`; the decision matches the clean run.
- `frame_mbs`=0 -> `frame_done` pulse, no `enable`. Reset asserted in WAIT4 at `blkidx`=7 -> all outputs 0 at once; a new `start` restarts cleanly at `mbnumber`=0.
